yacht_game_engine: RTL
======================

# yacht_game_engine

Parametrised turn/score engine for Yacht Dice, successor to the fixed two-player game FSM. It sequences N players through 12 rounds and enforces a per-turn roll limit. It tracks a used-category mask and an accumulated score per player, and declares the winner at game end. It sits between the button debouncers and the dice manager / score calculator / display and LCD controllers: it drives `roll_en` to the dice manager and `cat_idx` to the score calculator, and samples `cand_score` back.

## Interface
Parameters:
- `NUM_PLAYERS`, 2: players, 2..4; `PW = $clog2(NUM_PLAYERS)` (min 1).
- `MAX_ROLLS`, 3: rolls allowed per turn, 1..7.
- `NUM_CATS`, 12: categories; also the number of rounds. `CW = 4`.
- `SCORE_W`, 9: per-player total width (max legal total 323).

Ports:
- `clk`  in  1  system clock; the block uses this one clock only.
- `reset_n`  in  1  reset, synchronous and active-low.
- `roll_req`, `sel_req`, `prev_req`, `next_req`  in  1 each  single-cycle pulses from debouncers.
- `cand_score`  in  8  score of the current dice for `cat_idx` (combinational from the calculator).
- `score_rd_sel`  in  PW  player whose total appears on `score_rd_data`.
- `roll_en`  out  1  one-cycle roll strobe to the dice manager.
- `cat_idx`  out  CW  highlighted category.
- `player`  out  PW  current player, 0-based.
- `round_num`  out  4  round, 1..NUM_CATS.
- `rolls_left`  out  3  rolls remaining this turn.
- `used_mask`  out  NUM_CATS  categories already used by `player`.
- `state`  out  4  state code for the display/LCD.
- `score_rd_data`  out  SCORE_W  total of player `score_rd_sel`.
- `game_over`, `tie`  out  1 each; `winner`  out  PW.

## Operation
- States: IDLE(0), WAIT_ROLL(1), ROLL(2), CHOOSE(3), COMMIT(4), ADVANCE(5), OVER(6).
- IDLE/WAIT_ROLL: `roll_req` → ROLL. All other requests are ignored.
- ROLL: pulse `roll_en`, decrement `rolls_left`, → CHOOSE.
- CHOOSE: one request is acted on per cycle, priority sel > roll > next > prev.
  - `sel_req` with `cat_idx` unused: latch `cand_score` → COMMIT.
  - `sel_req` with `cat_idx` used: ignored.
  - `roll_req` with `rolls_left>0` → ROLL. With `rolls_left==0` it is ignored.
  - `next_req`/`prev_req`: move `cat_idx` to the next/previous unused category, circularly with wrap-around. If no other category is unused, `cat_idx` stays put.
- COMMIT: add the latched score to the current player's total, set the mask bit → ADVANCE.
- ADVANCE:
  - `player` increments. When it wraps to 0, `round_num` increments.
  - `rolls_left` reloads to MAX_ROLLS. `cat_idx` becomes the lowest unused category of the new player.
  - If the last player just committed round NUM_CATS → OVER, otherwise → WAIT_ROLL.
- OVER: `game_over`=1.
  - `winner` is the lowest-indexed player holding the maximum total. `tie`=1 if two or more players hold that maximum.
  - `sel_req` clears all scores and masks and returns to IDLE. Other requests are ignored.
- Arithmetic: totals are unsigned SCORE_W; `cand_score` is zero-extended before the add. No saturation is needed because the legal maximum fits.
- Reset (synchronous, also mid-turn): state IDLE, `player`=0, `round_num`=1, `rolls_left`=MAX_ROLLS, `cat_idx`=0. All totals, masks and flags are cleared; `roll_en`=0, `game_over`=0, `tie`=0, `winner`=0.

## Timing
- Request at edge t → state change visible after t. A roll request gives `roll_en` high for exactly cycle t+1 (ROLL), and `rolls_left` decremented from t+2.
- `sel_req` at t: COMMIT at t+1. The total and mask update at t+2, and `player`/`round_num`/`cat_idx` advance at t+3.
- `score_rd_data` is a combinational read of registered totals; `game_over` is registered at entry to OVER.
- Requests arriving during ROLL, COMMIT or ADVANCE are dropped and not queued.

## Configuration
- `YACHT_UPPER_BONUS_EN`, when defined:
  - Per-player upper sum (categories 0..5) and a bonus-given flag are kept.
  - At COMMIT, the first time the upper sum reaches ≥63, 35 is added in the same cycle as the score.
- When undefined: there is no upper-sum register or flag, and totals are the plain sum.

## Structure
- Shared package `yacht_pkg`:
  - state codes;
  - category constants CAT_ACES..CAT_YACHT (0..11);
  - UPPER_BONUS_THRESH=63 and UPPER_BONUS_VAL=35.
- Sub-module `yacht_cat_picker`: combinational circular search of `used_mask` from `cat_idx`. It gives next-unused, prev-unused and lowest-unused outputs, and is instantiated once.

## Test plan
- Reset, then roll_req ×4 in one turn (MAX_ROLLS=3) → exactly 3 `roll_en` pulses, `rolls_left` 3→2→1→0, and the 4th request is ignored.
- P0 rolls, cand_score=25 on cat 11, sel → P0 total 25 at t+2, `used_mask[11]`=1, `player`=1 at t+3, `round_num` stays 1.
- `used_mask`=12'b0111_1111_1110, cat_idx=0 → next_req gives 11, next_req again gives 0, prev_req gives 11.
- sel_req and roll_req in the same CHOOSE cycle → COMMIT is taken, no `roll_en`, and `rolls_left` is unchanged.
- NUM_PLAYERS=3, full 12 rounds with final totals 150/150/90 → `game_over`=1, `winner`=0, `tie`=1. With the bonus enabled, an upper sum of 63 adds 35 exactly once.
- reset_n low for one cycle mid-CHOOSE in round 7 → all outputs return to their reset values at the next edge.

Source files
------------

// File: rtl/yacht_pkg.sv
// Shared constants for the Yacht Dice turn/score engine: state codes,
// category indices and the upper-section bonus rule.
package yacht_pkg;

  localparam int CW = 4;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_WAIT_ROLL = 4'd1;
  localparam logic [3:0] ST_ROLL      = 4'd2;
  localparam logic [3:0] ST_CHOOSE    = 4'd3;
  localparam logic [3:0] ST_COMMIT    = 4'd4;
  localparam logic [3:0] ST_ADVANCE   = 4'd5;
  localparam logic [3:0] ST_OVER      = 4'd6;

  localparam logic [CW-1:0] CAT_ACES       = 4'd0;
  localparam logic [CW-1:0] CAT_TWOS       = 4'd1;
  localparam logic [CW-1:0] CAT_THREES     = 4'd2;
  localparam logic [CW-1:0] CAT_FOURS      = 4'd3;
  localparam logic [CW-1:0] CAT_FIVES      = 4'd4;
  localparam logic [CW-1:0] CAT_SIXES      = 4'd5;
  localparam logic [CW-1:0] CAT_CHOICE     = 4'd6;
  localparam logic [CW-1:0] CAT_FOUR_KIND  = 4'd7;
  localparam logic [CW-1:0] CAT_FULL_HOUSE = 4'd8;
  localparam logic [CW-1:0] CAT_SMALL_STR  = 4'd9;
  localparam logic [CW-1:0] CAT_LARGE_STR  = 4'd10;
  localparam logic [CW-1:0] CAT_YACHT      = 4'd11;

  localparam int UPPER_BONUS_THRESH = 63;
  localparam int UPPER_BONUS_VAL    = 35;

endpackage

// File: rtl/yacht_cat_picker.sv
// Circular search of a player's used-category mask: nearest unused category
// after / before the highlighted one, and the lowest unused category overall.
module yacht_cat_picker
  import yacht_pkg::*;
#(
  parameter int NUM_CATS = 12
) (
  input  logic [NUM_CATS-1:0] used_mask,
  input  logic [CW-1:0]       cat_idx,
  output logic [CW-1:0]       next_idx,
  output logic [CW-1:0]       prev_idx,
  output logic [CW-1:0]       low_idx
);

  localparam int IW = $clog2(NUM_CATS);

  always_comb begin
    logic [IW-1:0] j;
    logic          next_found;
    logic          prev_found;
    logic          low_found;
    next_idx   = cat_idx;
    prev_idx   = cat_idx;
    low_idx    = '0;
    next_found = 1'b0;
    prev_found = 1'b0;
    low_found  = 1'b0;
    j          = '0;
    // Offsets never reach 0, so a fully used mask leaves the highlight in place.
    for (int k = 1; k < NUM_CATS; k++) begin
      j = IW'((int'(cat_idx) + k) % NUM_CATS);
      if (!next_found && !used_mask[j]) begin
        next_idx   = CW'(j);
        next_found = 1'b1;
      end
      j = IW'((int'(cat_idx) + NUM_CATS - k) % NUM_CATS);
      if (!prev_found && !used_mask[j]) begin
        prev_idx   = CW'(j);
        prev_found = 1'b1;
      end
    end
    for (int k = 0; k < NUM_CATS; k++) begin
      if (!low_found && !used_mask[k]) begin
        low_idx   = CW'(k);
        low_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/yacht_game_engine.sv
// Yacht Dice turn/score engine: sequences players through the rounds, limits
// rolls per turn, keeps per-player totals and masks and declares the winner.
// Optional upper-section bonus is built when YACHT_UPPER_BONUS_EN is defined.
module yacht_game_engine
  import yacht_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int MAX_ROLLS   = 3,
  parameter int NUM_CATS    = 12,
  parameter int SCORE_W     = 9,
  localparam int PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                roll_req,
  input  logic                sel_req,
  input  logic                prev_req,
  input  logic                next_req,
  input  logic [7:0]          cand_score,
  input  logic [PW-1:0]       score_rd_sel,
  output logic                roll_en,
  output logic [CW-1:0]       cat_idx,
  output logic [PW-1:0]       player,
  output logic [3:0]          round_num,
  output logic [2:0]          rolls_left,
  output logic [NUM_CATS-1:0] used_mask,
  output logic [3:0]          state,
  output logic [SCORE_W-1:0]  score_rd_data,
  output logic                game_over,
  output logic                tie,
  output logic [PW-1:0]       winner
);

  // Storage covers every encodable player index so reads by any select are in range.
  localparam int NP2 = 1 << PW;

  logic [3:0]          state_q, state_d;
  logic [PW-1:0]       player_q, player_d;
  logic [3:0]          round_q, round_d;
  logic [2:0]          rolls_q, rolls_d;
  logic [CW-1:0]       cat_q, cat_d;
  logic                game_over_q, game_over_d;
  logic                tie_q, tie_d;
  logic [PW-1:0]       winner_q, winner_d;
  logic [7:0]          latch_q, latch_d;
  logic [SCORE_W-1:0]  total_q [NP2];
  logic [SCORE_W-1:0]  total_d [NP2];
  logic [NUM_CATS-1:0] mask_q  [NP2];
  logic [NUM_CATS-1:0] mask_d  [NP2];
`ifdef YACHT_UPPER_BONUS_EN
  logic [SCORE_W-1:0]  upper_q [NP2];
  logic [SCORE_W-1:0]  upper_d [NP2];
  logic [NP2-1:0]      bonus_q, bonus_d;
  logic [SCORE_W-1:0]  upper_sum;
`endif

  logic [PW-1:0]       nxt_player;
  logic                last_player;
  logic [NUM_CATS-1:0] pick_mask;
  logic [CW-1:0]       next_idx, prev_idx, low_idx;
  logic [PW-1:0]       win_c;
  logic                tie_c;

  function automatic logic [SCORE_W-1:0] add_score(input logic [SCORE_W-1:0] acc,
                                                   input logic [7:0]         pts);
    return acc + SCORE_W'(pts);
  endfunction

  assign last_player = (player_q == PW'(NUM_PLAYERS - 1));
  assign nxt_player  = last_player ? '0 : player_q + 1'b1;
  // During ADVANCE the lowest-unused search must look at the incoming player.
  assign pick_mask   = (state_q == ST_ADVANCE) ? mask_q[nxt_player] : mask_q[player_q];

  yacht_cat_picker #(.NUM_CATS(NUM_CATS)) u_picker (
    .used_mask (pick_mask),
    .cat_idx   (cat_q),
    .next_idx  (next_idx),
    .prev_idx  (prev_idx),
    .low_idx   (low_idx)
  );

  always_comb begin
    logic [SCORE_W-1:0] best;
    logic [2:0]         n_best;
    best   = total_q[0];
    win_c  = '0;
    n_best = '0;
    for (int p = 1; p < NUM_PLAYERS; p++) begin
      if (total_q[p] > best) begin
        best  = total_q[p];
        win_c = PW'(p);
      end
    end
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (total_q[p] == best) n_best = n_best + 3'd1;
    end
    tie_c = (n_best >= 3'd2);
  end

  always_comb begin
    state_d     = state_q;
    player_d    = player_q;
    round_d     = round_q;
    rolls_d     = rolls_q;
    cat_d       = cat_q;
    game_over_d = game_over_q;
    tie_d       = tie_q;
    winner_d    = winner_q;
    latch_d     = latch_q;
    total_d     = total_q;
    mask_d      = mask_q;
`ifdef YACHT_UPPER_BONUS_EN
    upper_d     = upper_q;
    bonus_d     = bonus_q;
    upper_sum   = '0;
`endif
    case (state_q)
      ST_IDLE, ST_WAIT_ROLL: begin
        if (roll_req) state_d = ST_ROLL;
      end
      ST_ROLL: begin
        rolls_d = rolls_q - 3'd1;
        state_d = ST_CHOOSE;
      end
      ST_CHOOSE: begin
        if (sel_req && !mask_q[player_q][cat_q]) begin
          latch_d = cand_score;
          state_d = ST_COMMIT;
        end else if (roll_req && (rolls_q != 3'd0)) begin
          state_d = ST_ROLL;
        end else if (next_req) begin
          cat_d = next_idx;
        end else if (prev_req) begin
          cat_d = prev_idx;
        end
      end
      ST_COMMIT: begin
        total_d[player_q]       = add_score(total_q[player_q], latch_q);
        mask_d[player_q][cat_q] = 1'b1;
`ifdef YACHT_UPPER_BONUS_EN
        if (cat_q <= CAT_SIXES) begin
          upper_sum         = add_score(upper_q[player_q], latch_q);
          upper_d[player_q] = upper_sum;
          if (!bonus_q[player_q] && (upper_sum >= SCORE_W'(UPPER_BONUS_THRESH))) begin
            total_d[player_q] = add_score(total_q[player_q], latch_q) + SCORE_W'(UPPER_BONUS_VAL);
            bonus_d[player_q] = 1'b1;
          end
        end
`endif
        state_d = ST_ADVANCE;
      end
      ST_ADVANCE: begin
        rolls_d = 3'(MAX_ROLLS);
        cat_d   = low_idx;
        if (last_player && (round_q == 4'(NUM_CATS))) begin
          player_d    = '0;
          game_over_d = 1'b1;
          tie_d       = tie_c;
          winner_d    = win_c;
          state_d     = ST_OVER;
        end else begin
          player_d = nxt_player;
          if (last_player) round_d = round_q + 4'd1;
          state_d = ST_WAIT_ROLL;
        end
      end
      ST_OVER: begin
        if (sel_req) begin
          for (int p = 0; p < NP2; p++) begin
            total_d[p] = '0;
            mask_d[p]  = '0;
`ifdef YACHT_UPPER_BONUS_EN
            upper_d[p] = '0;
`endif
          end
`ifdef YACHT_UPPER_BONUS_EN
          bonus_d = '0;
`endif
          player_d    = '0;
          round_d     = 4'd1;
          rolls_d     = 3'(MAX_ROLLS);
          cat_d       = '0;
          game_over_d = 1'b0;
          tie_d       = 1'b0;
          winner_d    = '0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      player_q    <= '0;
      round_q     <= 4'd1;
      rolls_q     <= 3'(MAX_ROLLS);
      cat_q       <= '0;
      game_over_q <= 1'b0;
      tie_q       <= 1'b0;
      winner_q    <= '0;
      for (int p = 0; p < NP2; p++) begin
        total_q[p] <= '0;
        mask_q[p]  <= '0;
`ifdef YACHT_UPPER_BONUS_EN
        upper_q[p] <= '0;
`endif
      end
`ifdef YACHT_UPPER_BONUS_EN
      bonus_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      player_q    <= player_d;
      round_q     <= round_d;
      rolls_q     <= rolls_d;
      cat_q       <= cat_d;
      game_over_q <= game_over_d;
      tie_q       <= tie_d;
      winner_q    <= winner_d;
      total_q     <= total_d;
      mask_q      <= mask_d;
`ifdef YACHT_UPPER_BONUS_EN
      upper_q     <= upper_d;
      bonus_q     <= bonus_d;
`endif
    end
  end

  // The latched score is only consumed in COMMIT, which always follows a fresh load.
  always_ff @(posedge clk) begin
    latch_q <= latch_d;
  end

  assign roll_en       = (state_q == ST_ROLL);
  assign cat_idx       = cat_q;
  assign player        = player_q;
  assign round_num     = round_q;
  assign rolls_left    = rolls_q;
  assign used_mask     = mask_q[player_q];
  assign state         = state_q;
  assign score_rd_data = total_q[score_rd_sel];
  assign game_over     = game_over_q;
  assign tie           = tie_q;
  assign winner        = winner_q;

endmodule
